bidir_bus_ctrl: RTL

Half-duplex controller for a shared DW-bit bidirectional data bus. It produces the data/enable pair that feeds the pad tristate buffer and samples the pad readback. Requests arrive on a valid/ready interface and are sequenced with drive, hold and turnaround phases, so the block never drives the bus while the far end may be driving. It sits directly upstream of the bidirectional pad cell, which converts `pad_out`/`pad_oe` into the inout pin and returns the pin value on `pad_in`.

---
 rtl/bidir_bus_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bidir_bus_ctrl.sv
// rtl/bidir_bus_ctrl.sv - half-duplex bidirectional bus controller with drive/hold/turnaround sequencing
// Optional pad parity is enabled with `define BIDIR_BUS_PARITY_EN.
module bidir_bus_ctrl #(
  parameter int DW       = 8,
  parameter int HOLD_CYC = 1,
  parameter int TURN_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [DW-1:0] pad_out,
  output logic          pad_oe,
  input  logic [DW-1:0] pad_in,
  output logic          bus_strobe
`ifdef BIDIR_BUS_PARITY_EN
  ,
  output logic          pad_par_out,
  input  logic          pad_par_in,
  output logic          rsp_perr
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_HOLD, S_RELEASE, S_WAIT, S_SAMPLE
  } state_t;

  localparam logic [3:0] HOLD_LD = 4'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [3:0] TURN_LD = 4'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  state_t          r_state, w_next_state;
  logic [3:0]      r_cnt, w_next_cnt;
  logic [DW-1:0]   r_wdata, w_next_wdata;
  logic [DW-1:0]   r_pad_out, r_rsp_rdata;
  logic            r_pad_oe, r_strobe, r_rsp_valid;
  logic            w_accept, w_done, w_next_oe, w_next_strobe;

  always_comb begin
    w_accept     = req_valid && (r_state == S_IDLE);
    w_next_state = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = req_wr ? S_DRIVE : S_WAIT;
      S_DRIVE:   w_next_state = (HOLD_CYC == 0) ? S_RELEASE : S_HOLD;
      S_HOLD:    if (r_cnt == 4'd0) w_next_state = S_RELEASE;
      S_RELEASE: if (r_cnt == 4'd0) begin
                   w_next_state = S_IDLE;
                   w_done       = 1'b1;
                 end
      S_WAIT:    if (r_cnt == 4'd0) w_next_state = S_SAMPLE;
      S_SAMPLE:  begin
                   w_next_state = S_IDLE;
                   w_done       = 1'b1;
                 end
      default:   w_next_state = S_IDLE;
    endcase

    // Shared down-counter is reloaded whenever a new state is entered.
    w_next_cnt = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
    if (w_next_state != r_state) begin
      case (w_next_state)
        S_HOLD:           w_next_cnt = HOLD_LD;
        S_RELEASE, S_WAIT: w_next_cnt = TURN_LD;
        default:          w_next_cnt = 4'd0;
      endcase
    end

    w_next_wdata  = w_accept ? req_wdata : r_wdata;
    w_next_oe     = (w_next_state == S_DRIVE) || (w_next_state == S_HOLD);
    w_next_strobe = (w_next_state == S_DRIVE) || (w_next_state == S_SAMPLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_wdata     <= '0;
      r_pad_oe    <= 1'b0;
      r_pad_out   <= '0;
      r_strobe    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_wdata     <= w_next_wdata;
      r_pad_oe    <= w_next_oe;
      r_pad_out   <= w_next_oe ? w_next_wdata : '0;
      r_strobe    <= w_next_strobe;
      r_rsp_valid <= w_done;
      if (r_state == S_SAMPLE) r_rsp_rdata <= pad_in;
    end
  end

`ifdef BIDIR_BUS_PARITY_EN
  logic r_par_out, r_perr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_out <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_par_out <= w_next_oe ? ^w_next_wdata : 1'b0;
      if (r_state == S_SAMPLE) r_perr <= (^pad_in) ^ pad_par_in;
      else if (r_state == S_RELEASE && w_done) r_perr <= 1'b0;
    end
  end

  assign pad_par_out = r_par_out;
  assign rsp_perr    = r_perr;
`endif

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign pad_out    = r_pad_out;
  assign pad_oe     = r_pad_oe;
  assign bus_strobe = r_strobe;

endmodule
